// File: rtl/seq_detector_param_pkg.sv
// Shared constants and helpers for the parametrised sequence detector.
// Keeps the legal pattern-length range and history-counter sizing in one place.
package seq_detector_param_pkg;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 16;

  function automatic int unsigned fill_bits(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; the count holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial detector for a WIDTH-bit pattern with Mealy and Moore match outputs.
// Matching is gated until WIDTH-1 real bits of history have been collected.
module seq_detector_param
  import seq_detector_param_pkg::*;
#(
  parameter int unsigned         WIDTH   = 4,
  parameter logic [WIDTH-1:0]    PATTERN = 4'b1011,
  parameter int unsigned         COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               x,
  input  logic               overlap,
  input  logic               cnt_clr,
  output logic               z_mealy,
  output logic               z_moore,
  output logic [COUNT_W-1:0] match_count
);

  localparam int unsigned FW = fill_bits(WIDTH);
  localparam logic [FW-1:0] FILL_MAX = FW'(WIDTH - 1);

  if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_bad_width
    $error("seq_detector_param: WIDTH must be in 2..16");
  end

  logic [WIDTH-2:0] hist_q;
  logic [WIDTH-2:0] hist_d;
  logic [FW-1:0]    fill_q;
  logic [FW-1:0]    fill_d;
  logic             z_moore_q;
  logic             z_moore_d;
  logic [WIDTH-1:0] window;
  logic             match;

  assign window = {hist_q, x};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q    <= '0;
      fill_q    <= '0;
      z_moore_q <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      z_moore_q <= z_moore_d;
    end
  end

  // Next-state
  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    z_moore_d = match;
    unique case (1'b1)
      !en: begin
        hist_d = hist_q;
        fill_d = fill_q;
      end
      match && !overlap: begin
        hist_d = '0;
        fill_d = '0;
      end
      default: begin
        hist_d = window[WIDTH-2:0];
        fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
      end
    endcase
  end

  // Outputs
  always_comb begin
    match   = en && (fill_q == FILL_MAX) && (window == PATTERN);
    z_mealy = match;
    z_moore = z_moore_q;
  end

  sat_counter #(
    .W(COUNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .inc  (match),
    .q    (match_count)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param with an expected-output queue.
// Two instances share stimulus: an 8-bit and a 2-bit match counter.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       x;
  logic       overlap;
  logic       cnt_clr;
  logic       z_mealy8;
  logic       z_moore8;
  logic [7:0] cnt8;
  logic       z_mealy2;
  logic       z_moore2;
  logic [1:0] cnt2;

  int n_cmp = 0;
  int n_err = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  seq_detector_param #(
    .WIDTH(4), .PATTERN(4'b1011), .COUNT_W(8)
  ) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x),
    .overlap(overlap), .cnt_clr(cnt_clr),
    .z_mealy(z_mealy8), .z_moore(z_moore8),
    .match_count(cnt8)
  );

  seq_detector_param #(
    .WIDTH(4), .PATTERN(4'b1011), .COUNT_W(2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x),
    .overlap(overlap), .cnt_clr(cnt_clr),
    .z_mealy(z_mealy2), .z_moore(z_moore2),
    .match_count(cnt2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic xv, input logic ev,
                      input logic cv, input logic em);
    logic e;
    @(negedge clk);
    x = xv; en = ev; cnt_clr = cv;
    exp_q.push_back(em);
    #1;
    e = exp_q.pop_front();
    chk("z_mealy", {31'd0, z_mealy8}, {31'd0, e});
    chk("z_mealy_c2", {31'd0, z_mealy2}, {31'd0, e});
    @(posedge clk);
    #1;
    chk("z_moore", {31'd0, z_moore8}, {31'd0, e});
  endtask

  initial begin
    logic e;
    rst_n = 1'b0; en = 1'b0; x = 1'b0;
    overlap = 1'b1; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mealy", {31'd0, z_mealy8}, 32'd0);
    chk("rst_moore", {31'd0, z_moore8}, 32'd0);
    chk("rst_cnt", {24'd0, cnt8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // zeros never match
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("zeros_cnt", {24'd0, cnt8}, 32'd0);

    // overlapping: 1,0,1,1,0,1,1
    overlap = 1'b1;
    step(1, 1, 0, 0); step(0, 1, 0, 0);
    step(1, 1, 0, 0); step(1, 1, 0, 1);
    step(0, 1, 0, 0); step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    chk("ovl_cnt", {24'd0, cnt8}, 32'd2);

    // flush, then non-overlapping
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    overlap = 1'b0;
    step(1, 1, 0, 0); step(0, 1, 0, 0);
    step(1, 1, 0, 0); step(1, 1, 0, 1);
    step(0, 1, 0, 0); step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("novl_cnt", {24'd0, cnt8}, 32'd3);
    step(0, 1, 0, 0); step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    chk("novl_cnt2", {24'd0, cnt8}, 32'd4);

    // enable gap inside the pattern
    step(1, 1, 0, 0); step(0, 1, 0, 0);
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 0, 0, 0); step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0); step(1, 1, 0, 1);
    chk("gap_cnt", {24'd0, cnt8}, 32'd5);
    chk("gap_cnt2", {30'd0, cnt2}, 32'd3);

    // saturation of the 2-bit counter
    step(0, 0, 1, 0);
    chk("clr_cnt", {24'd0, cnt8}, 32'd0);
    chk("clr_cnt2", {30'd0, cnt2}, 32'd0);
    overlap = 1'b1;
    for (int r = 0; r < 4; r++) begin
      if (r == 0) begin
        step(1, 1, 0, 0);
      end else begin
        step(0, 1, 0, 0);
      end
      step(r == 0 ? 1'b0 : 1'b1, 1, 0, 0);
      if (r == 0) begin
        step(1, 1, 0, 0);
        step(1, 1, 0, 1);
      end else begin
        step(1, 1, 0, 1);
      end
      chk("sat_cnt2", {30'd0, cnt2}, (r >= 2) ? 32'd3 : 32'(r + 1));
    end
    chk("sat_cnt8", {24'd0, cnt8}, 32'd4);
    // clear on the cycle of a match
    step(0, 1, 0, 0); step(1, 1, 0, 0);
    step(1, 1, 1, 1);
    cnt_clr = 1'b0;
    chk("clrm_cnt8", {24'd0, cnt8}, 32'd0);
    chk("clrm_cnt2", {30'd0, cnt2}, 32'd0);

    // async reset mid-pattern
    step(1, 1, 0, 0); step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    step(1, 1, 0, 0); step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    @(negedge clk);
    x = 1'b1; en = 1'b1;
    exp_q.push_back(1'b1);
    #1;
    e = exp_q.pop_front();
    chk("pre_rst_mealy", {31'd0, z_mealy8}, {31'd0, e});
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_mealy", {31'd0, z_mealy8}, 32'd0);
    chk("arst_moore", {31'd0, z_moore8}, 32'd0);
    chk("arst_cnt", {24'd0, cnt8}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 0, 0);
    step(1, 1, 0, 0); step(0, 1, 0, 0);
    step(1, 1, 0, 0); step(1, 1, 0, 1);
    chk("post_rst_cnt", {24'd0, cnt8}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
